fir_tap_mac: RTL

FIR_TAP_MAC -- requirements
Module: fir_tap_mac

---
 rtl/fir_tap_mac.sv | 117 +++++++++++
 1 files changed

// File: rtl/fir_tap_mac.sv
// Sequential single-multiplier FIR tap accumulator: walks NTAP taps one per clock,
// then rounds, saturates and publishes one output sample.
module fir_tap_mac #(
    parameter int DW   = 14,
    parameter int CW   = 14,
    parameter int NTAP = 17,
    parameter int FRAC = 13,
    parameter int OW   = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    output logic [4:0]           tap_idx,
    input  logic signed [DW-1:0] tap_data,
    input  logic signed [CW-1:0] coef_data,
    output logic                 busy,
    output logic                 out_valid,
    output logic signed [OW-1:0] y
);

    localparam int PW = DW + CW;
    localparam int AW = PW + 5;

    localparam logic signed [AW:0] HALF  = {{(AW-FRAC+1){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [AW:0] Y_MAX = {{(AW+2-OW){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW:0] Y_MIN = {{(AW+2-OW){1'b1}}, {(OW-1){1'b0}}};
    localparam logic [4:0]         LAST  = 5'(NTAP - 1);

    typedef enum logic {
        IDLE = 1'b0,
        MAC  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [4:0]            tap_idx_q, tap_idx_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic signed [OW-1:0]  y_q, y_d;
    logic                  ov_q, ov_d;

    logic signed [PW-1:0]  prod;
    logic signed [AW-1:0]  acc_sum;
    logic signed [AW:0]    rnd;
    logic signed [AW:0]    shifted;
    logic signed [OW-1:0]  y_sat;

    // Datapath: product of the current tap, running sum, then round-half-up and clamp.
    always_comb begin
        prod    = tap_data * coef_data;
        acc_sum = acc_q + {{5{prod[PW-1]}}, prod};
        rnd     = {acc_sum[AW-1], acc_sum} + HALF;
        shifted = rnd >>> FRAC;
        if (shifted > Y_MAX) begin
            y_sat = Y_MAX[OW-1:0];
        end else if (shifted < Y_MIN) begin
            y_sat = Y_MIN[OW-1:0];
        end else begin
            y_sat = shifted[OW-1:0];
        end
    end

    // NOTE: every signal gets a hold/default value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        tap_idx_d = tap_idx_q;
        acc_d     = acc_q;
        y_d       = y_q;
        ov_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = MAC;
                    acc_d     = '0;
                    tap_idx_d = '0;
                end
            end
            MAC: begin
                acc_d     = acc_sum;
                tap_idx_d = tap_idx_q + 5'd1;
                if (tap_idx_q == LAST) begin
                    y_d       = y_sat;
                    ov_d      = 1'b1;
                    tap_idx_d = '0;
                    acc_d     = '0;
                    // A start on the final tap chains straight into the next sample.
                    state_d   = start ? MAC : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            tap_idx_q <= '0;
            acc_q     <= '0;
            y_q       <= '0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            tap_idx_q <= tap_idx_d;
            acc_q     <= acc_d;
            y_q       <= y_d;
            ov_q      <= ov_d;
        end
    end

    assign tap_idx   = tap_idx_q;
    assign busy      = (state_q == MAC);
    assign out_valid = ov_q;
    assign y         = y_q;

endmodule
